// File: rtl/xps2_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: default timing,
// FSM state encoding and the frame parity helper.
package xps2_tx_pkg;

    localparam int unsigned INHIBIT_CYCLES_DEF = 5000;
    localparam int unsigned REQ_TIMEOUT_DEF    = 750000;
    localparam int unsigned BIT_TIMEOUT_DEF    = 100000;
    localparam int unsigned CNT_W_DEF          = 20;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INHIBIT   = 4'd1,
        ST_REQ       = 4'd2,
        ST_DATA      = 4'd3,
        ST_PARITY    = 4'd4,
        ST_STOP      = 4'd5,
        ST_WAIT_IDLE = 4'd6,
        ST_DONE      = 4'd7,
        ST_FAIL      = 4'd8
    } tx_state_e;

    // Odd parity: the nine bits {parity, data} always carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/xps2_tx_if.sv
// Host-side command/status interface of the PS/2 transmitter.
interface xps2_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_ack_ok;
    logic       tx_error;
    logic       rx_inhibit;

    modport master (
        output tx_data, tx_start,
        input  tx_busy, tx_done, tx_ack_ok, tx_error, rx_inhibit
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_busy, tx_done, tx_ack_ok, tx_error, rx_inhibit
    );
endinterface

// File: rtl/xps2_tx_sync.sv
// Two-flop synchronizer for the PS/2 CLK and DATA pads plus a one-cycle
// pulse on each synchronized CLK falling edge. Flops reset to 1 so that an
// idle (released) bus produces no spurious edge right after reset.
module xps2_tx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic fall_o
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    // Pad synchronization and previous-value tracking for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_s_o  = clk_sync_q;
    assign data_s_o = data_sync_q;
    assign fall_o   = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/xps2_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, requests to send with a
// start bit, then shifts out eight data bits LSB first, odd parity and a
// released stop bit on device-generated falling CLK edges, and finally checks
// the device ACK. Every transfer ends with a single tx_done pulse.
module xps2_tx
    import xps2_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned REQ_TIMEOUT    = REQ_TIMEOUT_DEF,
    parameter int unsigned BIT_TIMEOUT    = BIT_TIMEOUT_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    xps2_tx_if.slave  bus,
    input  logic      ps2_clk_i,
    input  logic      ps2_data_i,
    output logic      ps2_clk_low_o,
    output logic      ps2_data_low_o
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LIM  = CNT_W'(BIT_TIMEOUT);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       idx_q, idx_d;
    logic [8:0]       shift_q, shift_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             error_q, error_d;
    logic             acked_q, acked_d;
    logic             fail_now;

    logic clk_s, data_s, fall_edge;

    xps2_tx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_s_o    (clk_s),
        .data_s_o   (data_s),
        .fall_o     (fall_edge)
    );

    // State, timer, shifter and registered line/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            error_q    <= 1'b0;
            acked_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            error_q    <= error_d;
            acked_q    <= acked_d;
        end
    end

    // Next-state and output logic; data only changes right after a falling
    // edge so the device never sees it move while CLK is high.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + CNT_W'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_ok_d   = ack_ok_q;
        error_d    = error_q;
        acked_d    = acked_q;
        fail_now   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (bus.tx_start) begin
                    shift_d    = {odd_parity(bus.tx_data), bus.tx_data};
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    ack_ok_d   = 1'b0;
                    error_d    = 1'b0;
                    acked_d    = 1'b0;
                    clk_low_d  = 1'b1;
                    data_low_d = 1'b0;
                    state_d    = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Start bit goes low one cycle before CLK is released.
                if (data_low_q) begin
                    clk_low_d = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_REQ;
                end else if (timer_q == INH_LAST) begin
                    data_low_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (fall_edge) begin
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[8:1]};
                    idx_d      = 4'd1;
                    timer_d    = '0;
                    state_d    = ST_DATA;
                end else if (timer_q >= REQ_LAST) begin
                    fail_now = 1'b1;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    // With idx at 8 all data bits are out and shift_q[0] is parity.
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[8:1]};
                    idx_d      = idx_q + 4'd1;
                    timer_d    = '0;
                    if (idx_q == 4'd8) begin
                        state_d = ST_PARITY;
                    end
                end else if (timer_q >= BIT_LIM) begin
                    fail_now = 1'b1;
                end
            end
            ST_PARITY: begin
                if (fall_edge) begin
                    data_low_d = 1'b0;
                    timer_d    = '0;
                    state_d    = ST_STOP;
                end else if (timer_q >= BIT_LIM) begin
                    fail_now = 1'b1;
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    acked_d = ~data_s;
                    timer_d = '0;
                    state_d = ST_WAIT_IDLE;
                end else if (timer_q >= BIT_LIM) begin
                    fail_now = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    if (acked_q) begin
                        ack_ok_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        fail_now = 1'b1;
                    end
                end else if (timer_q >= BIT_LIM) begin
                    fail_now = 1'b1;
                end
            end
            ST_DONE, ST_FAIL: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Failure releases both lines on entry, together with tx_done.
        if (fail_now) begin
            state_d    = ST_FAIL;
            done_d     = 1'b1;
            error_d    = 1'b1;
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
        end
    end

    assign ps2_clk_low_o  = clk_low_q;
    assign ps2_data_low_o = data_low_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_ack_ok  = ack_ok_q;
    assign bus.tx_error   = error_q;
    assign bus.rx_inhibit = busy_q;

endmodule

// File: tb/tb_xps2_tx.sv
// Bench for xps2_tx: open-drain bus with a behavioural keyboard model and a
// scoreboard of expected transfer results checked on every tx_done.
module tb_xps2_tx;
    import xps2_tx_pkg::*;

    localparam int INH  = 50;
    localparam int REQT = 400;
    localparam int BITT = 200;
    localparam int HP   = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    xps2_tx_if bus();

    logic dut_clk_low, dut_data_low;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    wire  clk_line  = ~(dut_clk_low | dev_clk_low);
    wire  data_line = ~(dut_data_low | dev_data_low);

    xps2_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_TIMEOUT    (REQT),
        .BIT_TIMEOUT    (BITT),
        .CNT_W          (20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .ps2_clk_i      (clk_line),
        .ps2_data_i     (data_line),
        .ps2_clk_low_o  (dut_clk_low),
        .ps2_data_low_o (dut_data_low)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack;
        logic       err;
        logic       chk;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [9:0] dev_bits = '0;
    int         dev_edges = 0;
    bit         dev_abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    // Monitor: scoreboard pop on tx_done plus continuous protocol properties.
    logic prev_busy = 1'b0, prev_done = 1'b0, prev_dl = 1'b0, prev_cl = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("rx_inhibit_eq_busy", bus.rx_inhibit, bus.tx_busy);
            if (prev_busy && !bus.tx_busy)
                check("busy_falls_after_done", prev_done, 1'b1);
            if (dut_data_low !== prev_dl && clk_line && prev_cl && !bus.tx_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL data_change_clk_high: got data_low %0b while CLK high, expected stable", dut_data_low);
            end
            if (bus.tx_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got tx_done, expected none");
                end else begin
                    e = sb.pop_front();
                    check("ack_ok", bus.tx_ack_ok, e.ack);
                    check("error", bus.tx_error, e.err);
                    check("clk_released", dut_clk_low, 1'b0);
                    check("data_released", dut_data_low, 1'b0);
                    if (e.chk)
                        check("frame_bits", dev_bits, {1'b1, e.par, e.data});
                end
            end
        end
        prev_busy = bus.tx_busy;
        prev_done = bus.tx_done;
        prev_dl   = dut_data_low;
        prev_cl   = clk_line;
    end

    // Keyboard model: waits for the request, clocks n_edges falling edges,
    // samples on rising edges and optionally pulls DATA low for the ACK.
    task automatic device_frame(input int n_edges, input bit ack);
        int t;
        dev_edges = 0;
        dev_bits  = '0;
        t = 0;
        while (!dut_clk_low && t < 20) begin @(posedge clk); t++; end
        if (!dut_clk_low) begin fail_timeout("inhibit_start"); return; end
        t = 0;
        while (dut_clk_low && t < INH + 20) begin @(posedge clk); t++; end
        if (dut_clk_low) begin fail_timeout("inhibit_release"); return; end
        check("start_bit", data_line, 1'b0);
        repeat (10) @(posedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            if (dev_abort) break;
            dev_clk_low = 1'b1;
            dev_edges   = e;
            repeat (HP) @(posedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) dev_bits[e-1] = data_line;
            if (e == 10 && ack) begin
                repeat (HP/2) @(posedge clk);
                dev_data_low = 1'b1;
                repeat (HP - HP/2) @(posedge clk);
            end else begin
                repeat (HP) @(posedge clk);
            end
            if (e == 11) dev_data_low = 1'b0;
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic start_pulse(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    task automatic expect_xfer(input logic [7:0] d, input logic par, input logic ack,
                               input logic err, input logic chk);
        exp_t e;
        e.data = d; e.par = par; e.ack = ack; e.err = err; e.chk = chk;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int base, input int max_cyc, input string name);
        int t;
        t = 0;
        while (done_cnt == base && t < max_cyc) begin @(posedge clk); t++; end
        if (done_cnt == base) begin
            fail_timeout(name);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time limit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_clk_low", dut_clk_low, 1'b0);
        check("rst_data_low", dut_data_low, 1'b0);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_done", bus.tx_done, 1'b0);
        check("rst_err_ack", {bus.tx_error, bus.tx_ack_ok}, 2'b00);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 1: 0xED with ACK, parity 1
        base = done_cnt;
        expect_xfer(8'hED, 1'b1, 1'b1, 1'b0, 1'b1);
        start_pulse(8'hED);
        device_frame(11, 1'b1);
        wait_done(base, 100, "done_0xED");
        repeat (10) @(negedge clk);
        check("ack_ok_hold", bus.tx_ack_ok, 1'b1);
        check("single_done_0xED", done_cnt, base + 1);

        // 2: 0x07 parity 0; a start coincident with tx_done must be ignored
        base = done_cnt;
        expect_xfer(8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
        start_pulse(8'h07);
        fork
            device_frame(11, 1'b1);
            begin
                t = 0;
                @(negedge clk);
                while (!bus.tx_done && t < 1000) begin @(negedge clk); t++; end
                if (!bus.tx_done) fail_timeout("done_0x07_watch");
                bus.tx_data  = 8'h99;
                bus.tx_start = 1'b1;
                @(negedge clk);
                bus.tx_start = 1'b0;
            end
        join
        wait_done(base, 100, "done_0x07");
        repeat (5) @(negedge clk);
        check("start_on_done_ignored", bus.tx_busy, 1'b0);
        check("single_done_0x07", done_cnt, base + 1);

        // 3: silent device -> request timeout
        base = done_cnt;
        expect_xfer(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        start_pulse(8'h12);
        t = 0;
        while (done_cnt == base && t < 600) begin @(posedge clk); t++; end
        if (done_cnt == base) begin
            fail_timeout("req_timeout");
            void'(sb.pop_front());
        end
        check("req_timeout_latency", (t >= INH + REQT - 5) && (t <= INH + REQT + 10), 1'b1);
        repeat (5) @(negedge clk);
        check("req_timeout_err_hold", bus.tx_error, 1'b1);

        // 4a: NACK (DATA left high at ack edge)
        base = done_cnt;
        expect_xfer(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        start_pulse(8'h5A);
        device_frame(11, 1'b0);
        wait_done(base, 100, "done_nack");

        // 4b: device stops after bit3 -> bit timeout
        base = done_cnt;
        expect_xfer(8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
        start_pulse(8'h81);
        device_frame(4, 1'b1);
        wait_done(base, BITT + 100, "done_bit_timeout");

        // 5: start pulses mid-frame with other data are ignored
        base = done_cnt;
        expect_xfer(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        start_pulse(8'h3C);
        fork
            device_frame(11, 1'b1);
            begin
                repeat (200) @(posedge clk);
                start_pulse(8'h55);
                repeat (150) @(posedge clk);
                start_pulse(8'hAA);
            end
        join
        wait_done(base, 100, "done_0x3C");
        repeat (5) @(negedge clk);
        check("single_done_0x3C", done_cnt, base + 1);

        // 6: reset during DATA (bit4 of 0xA5 is 0, so DATA is being pulled)
        base = done_cnt;
        dev_abort = 0;
        start_pulse(8'hA5);
        fork
            device_frame(11, 1'b1);
            begin
                t = 0;
                while (dev_edges < 5 && t < 1000) begin @(posedge clk); t++; end
                if (dev_edges < 5) fail_timeout("reach_bit4");
                repeat (10) @(posedge clk);
                #2;
                check("pre_reset_data_low", dut_data_low, 1'b1);
                rst_n = 1'b0;
                dev_abort = 1;
                #1;
                check("midrst_clk_low", dut_clk_low, 1'b0);
                check("midrst_data_low", dut_data_low, 1'b0);
                check("midrst_busy", bus.tx_busy, 1'b0);
                check("midrst_done", bus.tx_done, 1'b0);
            end
        join
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b1;
        dev_abort = 0;
        repeat (5) @(posedge clk);
        check("no_done_on_reset", done_cnt, base);

        // 6b: 0xFF after reset succeeds
        base = done_cnt;
        expect_xfer(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        start_pulse(8'hFF);
        device_frame(11, 1'b1);
        wait_done(base, 100, "done_0xFF");
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
